// File: rtl/player_motion_tracker.sv
// player_motion_tracker: frame-synchronous player-position integrator for the VGA box.
// Ports: clk_25mHz pixel clock; reset async active-low; frame_tick screenEnd;
//   accel_valid/accel_x_in/accel_y_in tilt sample strobe and signed axes;
//   game_state 0=start, 1/3=run, else freeze; pos_x/pos_y player centre;
//   pos_valid one-cycle update pulse; at_wall last update clamped an axis.
// Optional build macro VELOCITY_SMOOTH_EN adds a per-axis first-order tilt filter.
module player_motion_tracker #(
  parameter int SCREEN_W   = 640,
  parameter int SCREEN_H   = 480,
  parameter int SHIFT      = 4,
  parameter int DEADZONE   = 8,
  parameter int HALF_BIG   = 20,
  parameter int HALF_SMALL = 10
) (
  input  logic               clk_25mHz,
  input  logic               reset,
  input  logic               frame_tick,
  input  logic               accel_valid,
  input  logic signed [11:0] accel_x_in,
  input  logic signed [11:0] accel_y_in,
  input  logic [31:0]        game_state,
  output logic [31:0]        pos_x,
  output logic [31:0]        pos_y,
  output logic               pos_valid,
  output logic               at_wall
);
`ifdef VELOCITY_SMOOTH_EN
  localparam int HW = 14;
`else
  localparam int HW = 12;
`endif
  typedef enum logic [1:0] {S_START, S_RUN, S_FREEZE} state_t;
  state_t state_q, state_d;
  logic tick_q, edge_w, small_q, small_d, v1_q, wall_q, wall_d, pv_q;
  logic signed [HW-1:0] hx_q, hx_d, hy_q, hy_d, sx_q, sx_d, sy_q, sy_d;
  logic [9:0] px_q, px_d;
  logic [8:0] py_q, py_d;
  logic signed [11:0] half, hix, hiy, sum_x, sum_y, cx, cy;
  logic wx, wy;
  function automatic logic signed [11:0] step_f(input logic signed [HW-1:0] s);
    return (s >= -DEADZONE && s <= DEADZONE) ? 12'sd0 : 12'(s >>> SHIFT);
  endfunction
  assign edge_w = frame_tick & ~tick_q;
  always_comb begin
`ifdef VELOCITY_SMOOTH_EN
    hx_d = accel_valid ? hx_q + (({{2{accel_x_in[11]}}, accel_x_in} - hx_q) >>> 2) : hx_q;
    hy_d = accel_valid ? hy_q + (({{2{accel_y_in[11]}}, accel_y_in} - hy_q) >>> 2) : hy_q;
`else
    hx_d = accel_valid ? accel_x_in : hx_q;
    hy_d = accel_valid ? accel_y_in : hy_q;
`endif
    // snapshot reads the held registers before this edge's sample lands
    sx_d = edge_w ? hx_q : sx_q;
    sy_d = edge_w ? hy_q : sy_q;
    small_d = edge_w ? (game_state == 32'd3) : small_q;
    state_d = !edge_w ? state_q :
              (game_state == 32'd0) ? S_START :
              (game_state == 32'd1 || game_state == 32'd3) ? S_RUN : S_FREEZE;
    half = small_q ? 12'(HALF_SMALL) : 12'(HALF_BIG);
    hix = 12'(SCREEN_W - 1) - half;
    hiy = 12'(SCREEN_H - 1) - half;
    sum_x = $signed({2'b0, px_q}) + step_f(sx_q);
    sum_y = $signed({3'b0, py_q}) + step_f(sy_q);
    wx = (sum_x < half) || (sum_x > hix);
    wy = (sum_y < half) || (sum_y > hiy);
    cx = (sum_x < half) ? half : (sum_x > hix) ? hix : sum_x;
    cy = (sum_y < half) ? half : (sum_y > hiy) ? hiy : sum_y;
    px_d = !v1_q ? px_q : (state_q == S_START) ? 10'd320 : (state_q == S_RUN) ? cx[9:0] : px_q;
    py_d = !v1_q ? py_q : (state_q == S_START) ? 9'd240 : (state_q == S_RUN) ? cy[8:0] : py_q;
    wall_d = !v1_q ? wall_q : (state_q == S_RUN) & (wx | wy);
  end
  always_ff @(posedge clk_25mHz or negedge reset) begin
    if (!reset) begin
      tick_q <= 1'b0;
      hx_q <= '0;
      hy_q <= '0;
      sx_q <= '0;
      sy_q <= '0;
      small_q <= 1'b0;
      state_q <= S_START;
      v1_q <= 1'b0;
      px_q <= 10'd320;
      py_q <= 9'd240;
      wall_q <= 1'b0;
      pv_q <= 1'b0;
    end else begin
      tick_q <= frame_tick;
      hx_q <= hx_d;
      hy_q <= hy_d;
      sx_q <= sx_d;
      sy_q <= sy_d;
      small_q <= small_d;
      state_q <= state_d;
      v1_q <= edge_w;
      px_q <= px_d;
      py_q <= py_d;
      wall_q <= wall_d;
      pv_q <= v1_q;
    end
  end
  assign pos_x = {22'b0, px_q};
  assign pos_y = {23'b0, py_q};
  assign pos_valid = pv_q;
  assign at_wall = wall_q;
endmodule
